hypipe_pkt_meta_join: RTL

- Buffers 134b-format packets from the PHV generator, and buffers the per-packet metadata that the parser emits some cycles later.
- Joins each packet with its metadata in arrival order, then streams the packet out under a ready handshake.
- Per packet, it either passes the packet through, rewrites masked bytes of the head beat from metadata (generalised MAC replace), or drops it.
- Sits between the parser output and the egress port in the hybrid pipeline top, replacing the fixed-width packet/metadata FIFO pair.

---
 rtl/hypipe_pkg.sv | 26 ++
 rtl/hypipe_sync_fifo.sv | 54 +++++
 rtl/hypipe_pkt_meta_join.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hypipe_pkg.sv
// Shared definitions for the hybrid-pipeline packet/metadata join: beat tags,
// configuration modes, FSM state encoding and the beat-width helper.
package hypipe_pkg;

  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_REWRITE = 2'd1;
  localparam logic [1:0] MODE_RW_DROP = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DROP = 2'd3
  } join_state_t;

  // Beat = {tag[2], valid[4], data[data_w]}
  function automatic int beat_w(input int data_w);
    return data_w + 6;
  endfunction

endpackage

// File: rtl/hypipe_sync_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after rd_en).
// Writes when full and reads when empty are ignored; count stays exact.
module hypipe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [1 << AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hypipe_pkt_meta_join.sv
// Joins buffered packets with their later-arriving metadata in order, then
// passes, head-rewrites or drops each packet on a valid/ready egress stream.
module hypipe_pkt_meta_join
  import hypipe_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int META_W    = 128,
  parameter int PKT_AW    = 9,
  parameter int META_AW   = 4,
  parameter int MAX_BEATS = 128
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_pkt_valid,
  input  logic [DATA_W+5:0]   i_pkt,
  input  logic                i_meta_valid,
  input  logic [META_W-1:0]   i_meta,
  input  logic [1:0]          i_cfg_mode,
  input  logic [DATA_W/8-1:0] i_cfg_byte_en,
  output logic                o_pkt_valid,
  output logic [DATA_W+5:0]   o_pkt,
  input  logic                i_pkt_ready,
  output logic [31:0]         o_pkt_cnt,
  output logic [31:0]         o_drop_cnt,
  output logic [31:0]         o_adm_drop_cnt,
  output logic                o_meta_ovf,
  output logic [1:0]          o_dbg_state
);
  // Egress handshake: a beat moves on a rising edge where o_pkt_valid and
  // i_pkt_ready are both high; o_pkt_valid never drops and o_pkt never changes
  // while a beat is offered and not yet taken.
  localparam int BEAT_W = beat_w(DATA_W);
  localparam logic [PKT_AW:0] ADM_LIMIT = (PKT_AW+1)'((1 << PKT_AW) - MAX_BEATS);

  join_state_t       state;
  logic [1:0]        in_tag;
  logic              in_open;
  logic              room_ok;
  logic              pkt_wr;
  logic              pkt_rd;
  logic              meta_rd;
  logic              tail_wr;
  logic              start;
  logic              drop_now;
  logic              out_tail;
  logic              rd_tail;
  logic              xfer;
  logic [BEAT_W-1:0] pkt_rd_data;
  logic [BEAT_W-1:0] head_out;
  logic [PKT_AW:0]   pkt_count;
  logic [PKT_AW:0]   tail_cnt;
  logic              pkt_empty;
  logic              pkt_full;
  logic [META_W-1:0] meta_rd_data;
  logic [META_AW:0]  meta_count;
  logic              meta_empty;
  logic              meta_full;
  logic              unused_sig;

  assign in_tag   = i_pkt[DATA_W+5:DATA_W+4];
  assign room_ok  = (pkt_count <= ADM_LIMIT);
  // Heads decide admission; body/tail beats follow only an admitted head.
  assign pkt_wr   = i_pkt_valid & (in_tag[0] ? room_ok : in_open);
  assign tail_wr  = pkt_wr & ~pkt_full & in_tag[1];
  assign start    = (state == ST_IDLE) & (tail_cnt != '0) & ~meta_empty;
  assign out_tail = o_pkt[DATA_W+5];
  assign rd_tail  = pkt_rd_data[DATA_W+5];
  assign xfer     = o_pkt_valid & i_pkt_ready;
  assign drop_now = (i_cfg_mode == MODE_RW_DROP) & meta_rd_data[META_W-1];
  assign o_dbg_state = state;
  assign unused_sig  = ^{pkt_empty, meta_count, meta_rd_data};

  always_comb begin
    head_out = pkt_rd_data;
    if (i_cfg_mode == MODE_REWRITE || i_cfg_mode == MODE_RW_DROP) begin
      for (int k = 0; k < DATA_W/8; k++) begin
        if (i_cfg_byte_en[k]) head_out[8*k +: 8] = meta_rd_data[8*k +: 8];
      end
    end
  end

  // The read register always holds the beat after o_pkt while sending, so a
  // held-high ready drains one beat per cycle.
  always_comb begin
    pkt_rd  = 1'b0;
    meta_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        pkt_rd  = start;
        meta_rd = start;
      end
      ST_LOAD: pkt_rd = ~drop_now & ~rd_tail;
      ST_SEND: pkt_rd = xfer & ~out_tail & ~rd_tail;
      ST_DROP: pkt_rd = ~rd_tail;
      default: pkt_rd = 1'b0;
    endcase
  end

  hypipe_sync_fifo #(.WIDTH(BEAT_W), .AW(PKT_AW)) u_pkt_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .wr_en(pkt_wr), .wr_data(i_pkt),
    .rd_en(pkt_rd), .rd_data(pkt_rd_data), .count(pkt_count),
    .empty(pkt_empty), .full(pkt_full)
  );

  hypipe_sync_fifo #(.WIDTH(META_W), .AW(META_AW)) u_meta_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .wr_en(i_meta_valid), .wr_data(i_meta),
    .rd_en(meta_rd), .rd_data(meta_rd_data), .count(meta_count),
    .empty(meta_empty), .full(meta_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_open        <= 1'b0;
      tail_cnt       <= '0;
      o_adm_drop_cnt <= '0;
      o_meta_ovf     <= 1'b0;
    end else begin
      if (i_pkt_valid) begin
        if (in_tag[0]) begin
          in_open <= room_ok & ~in_tag[1];
          if (!room_ok) o_adm_drop_cnt <= o_adm_drop_cnt + 32'd1;
        end else if (in_tag[1]) begin
          in_open <= 1'b0;
        end
      end
      if (i_meta_valid && meta_full) o_meta_ovf <= 1'b1;
      case ({tail_wr, start})
        2'b10:   tail_cnt <= tail_cnt + 1'b1;
        2'b01:   tail_cnt <= tail_cnt - 1'b1;
        default: tail_cnt <= tail_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_pkt_valid <= 1'b0;
      o_pkt       <= '0;
      o_pkt_cnt   <= '0;
      o_drop_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: begin
          if (drop_now) begin
            state <= ST_DROP;
          end else begin
            o_pkt       <= head_out;
            o_pkt_valid <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            if (out_tail) begin
              o_pkt_valid <= 1'b0;
              o_pkt_cnt   <= o_pkt_cnt + 32'd1;
              state       <= ST_IDLE;
            end else begin
              o_pkt <= pkt_rd_data;
            end
          end
        end
        ST_DROP: begin
          if (rd_tail) begin
            o_drop_cnt <= o_drop_cnt + 32'd1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
